// File: rtl/bp_cfg_loader_if.sv
// rtl/bp_cfg_loader_if.sv - config write channel and microcode source channel of bp_cfg_loader
interface bp_cfg_loader_if #(
    parameter int num_core_p       = 1,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64
);
    localparam int core_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    logic                        cfg_v_o;
    logic                        cfg_ready_i;
    logic [core_width_lp-1:0]    cfg_core_o;
    logic [cfg_addr_width_p-1:0] cfg_addr_o;
    logic [cfg_data_width_p-1:0] cfg_data_o;
    logic                        ucode_v_i;
    logic [cfg_data_width_p-1:0] ucode_data_i;
    logic                        ucode_yumi_o;

    modport master (
        output cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, ucode_yumi_o,
        input  cfg_ready_i, ucode_v_i, ucode_data_i
    );

    modport slave (
        input  cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o, ucode_yumi_o,
        output cfg_ready_i, ucode_v_i, ucode_data_i
    );
endinterface

// File: rtl/bp_cfg_loader.sv
// rtl/bp_cfg_loader.sv - boot config sequencer: IDs, CCE microcode, mode, unfreeze (option: BP_CFG_LOADER_UCODE_EN)
module bp_cfg_loader #(
    parameter int num_core_p              = 1,
    parameter int num_cce_p               = 1,
    parameter int num_lce_p               = 2,
    parameter int num_cce_instr_ram_els_p = 256,
    parameter int cfg_addr_width_p        = 16,
    parameter int cfg_data_width_p        = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bp_cfg_loader_if.master      cfg,
    output logic                 done_o
);
    localparam int CORE_W = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int AW     = cfg_addr_width_p;
    localparam int DW     = cfg_data_width_p;

    localparam logic [AW-1:0] ADDR_FREEZE  = AW'(16'h0000);
    localparam logic [AW-1:0] ADDR_CORE_ID = AW'(16'h0001);
    localparam logic [AW-1:0] ADDR_ICACHE  = AW'(16'h0002);
    localparam logic [AW-1:0] ADDR_DCACHE  = AW'(16'h0003);
    localparam logic [AW-1:0] ADDR_CCE_ID  = AW'(16'h0004);
    localparam logic [AW-1:0] ADDR_MODE    = AW'(16'h0005);
    localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(num_core_p - 1);

    if (num_cce_p != num_core_p) begin : g_bad_cce_count
        $error("bp_cfg_loader: num_cce_p must equal num_core_p");
    end
    if (num_lce_p != 2 * num_core_p) begin : g_bad_lce_count
        $error("bp_cfg_loader: num_lce_p must equal 2*num_core_p");
    end
    if (num_cce_instr_ram_els_p < 1) begin : g_bad_ram_els
        $error("bp_cfg_loader: num_cce_instr_ram_els_p must be at least 1");
    end

    typedef enum logic [2:0] {
        S_RESET,
        S_IDS,
`ifdef BP_CFG_LOADER_UCODE_EN
        S_UCODE,
`endif
        S_MODE,
        S_UNFREEZE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CORE_W-1:0]  core_q, core_d;
    logic [2:0]         sub_q, sub_d;
    logic               cfg_v;
    logic [AW-1:0]      cfg_addr;
    logic [DW-1:0]      cfg_data;
    logic               ucode_yumi;
    logic               last_core;

`ifdef BP_CFG_LOADER_UCODE_EN
    localparam int WORD_W = (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(num_cce_instr_ram_els_p - 1);
    localparam logic [AW-1:0]     UCODE_BASE = AW'(16'h8000);
    localparam logic [DW-1:0]     MODE_DATA  = DW'(1);
    state_e             after_ids;
    logic [WORD_W-1:0]  word_q, word_d;

    assign after_ids = S_UCODE;
`else
    localparam logic [DW-1:0]     MODE_DATA  = DW'(0);
    state_e             after_ids;
    logic               unused_ucode;

    // Uncached boot: the microcode source is never consumed.
    assign after_ids    = S_MODE;
    assign unused_ucode = ^{cfg.ucode_v_i, cfg.ucode_data_i};
`endif

    assign last_core = (core_q == LAST_CORE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_RESET;
            core_q  <= '0;
            sub_q   <= '0;
`ifdef BP_CFG_LOADER_UCODE_EN
            word_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            core_q  <= core_d;
            sub_q   <= sub_d;
`ifdef BP_CFG_LOADER_UCODE_EN
            word_q  <= word_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        core_d     = core_q;
        sub_d      = sub_q;
`ifdef BP_CFG_LOADER_UCODE_EN
        word_d     = word_q;
`endif
        cfg_v      = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        ucode_yumi = 1'b0;
        done_o     = 1'b0;

        case (state_q)
            S_RESET: state_d = S_IDS;

            S_IDS: begin
                cfg_v = 1'b1;
                case (sub_q)
                    3'd0:    begin cfg_addr = ADDR_FREEZE;  cfg_data = DW'(1);                end
                    3'd1:    begin cfg_addr = ADDR_CORE_ID; cfg_data = DW'(core_q);           end
                    3'd2:    begin cfg_addr = ADDR_ICACHE;  cfg_data = DW'({core_q, 1'b0});   end
                    3'd3:    begin cfg_addr = ADDR_DCACHE;  cfg_data = DW'({core_q, 1'b1});   end
                    default: begin cfg_addr = ADDR_CCE_ID;  cfg_data = DW'(core_q);           end
                endcase
                if (cfg.cfg_ready_i) begin
                    if (sub_q == 3'd4) begin
                        sub_d = '0;
                        if (last_core) begin
                            core_d  = '0;
                            state_d = after_ids;
                        end else begin
                            core_d = core_q + CORE_W'(1);
                        end
                    end else begin
                        sub_d = sub_q + 3'd1;
                    end
                end
            end

`ifdef BP_CFG_LOADER_UCODE_EN
            // Payload passes straight through; the source holds it until yumi.
            S_UCODE: begin
                cfg_v      = cfg.ucode_v_i;
                cfg_addr   = UCODE_BASE + AW'(word_q);
                cfg_data   = cfg.ucode_data_i;
                ucode_yumi = cfg.ucode_v_i & cfg.cfg_ready_i;
                if (ucode_yumi) begin
                    if (word_q == LAST_WORD) begin
                        word_d = '0;
                        if (last_core) begin
                            core_d  = '0;
                            state_d = S_MODE;
                        end else begin
                            core_d = core_q + CORE_W'(1);
                        end
                    end else begin
                        word_d = word_q + WORD_W'(1);
                    end
                end
            end
`endif

            S_MODE: begin
                cfg_v    = 1'b1;
                cfg_addr = ADDR_MODE;
                cfg_data = MODE_DATA;
                if (cfg.cfg_ready_i) begin
                    if (last_core) begin
                        core_d  = '0;
                        state_d = S_UNFREEZE;
                    end else begin
                        core_d = core_q + CORE_W'(1);
                    end
                end
            end

            S_UNFREEZE: begin
                cfg_v    = 1'b1;
                cfg_addr = ADDR_FREEZE;
                cfg_data = '0;
                if (cfg.cfg_ready_i) begin
                    if (last_core) begin
                        core_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        core_d = core_q + CORE_W'(1);
                    end
                end
            end

            S_DONE: done_o = 1'b1;

            default: state_d = S_RESET;
        endcase
    end

    assign cfg.cfg_v_o      = cfg_v;
    assign cfg.cfg_core_o   = core_q;
    assign cfg.cfg_addr_o   = cfg_addr;
    assign cfg.cfg_data_o   = cfg_data;
    assign cfg.ucode_yumi_o = ucode_yumi;
endmodule

// File: tb/tb_bp_cfg_loader.sv
// tb/tb_bp_cfg_loader.sv - scoreboard bench for bp_cfg_loader with randomized backpressure and microcode gaps
module tb_bp_cfg_loader;
    localparam int N  = 2;
    localparam int E  = 3;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int CW = 1;
`ifdef BP_CFG_LOADER_UCODE_EN
    localparam int          NW     = N * E;
    localparam logic [63:0] MODE_D = 64'd1;
`else
    localparam int          NW     = 0;
    localparam logic [63:0] MODE_D = 64'd0;
`endif
    localparam int T = 7 * N + NW;

    typedef struct packed {
        logic [CW-1:0] core;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic done;
    always #5 clk = ~clk;

    bp_cfg_loader_if #(.num_core_p(N), .cfg_addr_width_p(AW), .cfg_data_width_p(DW)) bus ();

    bp_cfg_loader #(
        .num_core_p(N), .num_cce_p(N), .num_lce_p(2 * N),
        .num_cce_instr_ram_els_p(E), .cfg_addr_width_p(AW), .cfg_data_width_p(DW)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .cfg(bus), .done_o(done)
    );

    wr_t         exp_q[$];
    logic [63:0] ucode_mem [N*E];
    int          uidx = 0;
    int          mode = 0;
    int          gap = 0;
    bit          yumi_seen = 0;
    bit          yumi_ever = 0;
    bit          hold_pend = 0;
    wr_t         hold_wr;
    int          wr_cnt = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    assign bus.ucode_data_i = (uidx < N * E) ? ucode_mem[uidx] : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int c, input int a, input logic [63:0] d);
        wr_t w;
        w.core = CW'(c);
        w.addr = AW'(a);
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Reference write list straight from the boot sequence description.
    task automatic build_exp();
        exp_q.delete();
        for (int c = 0; c < N; c++) begin
            push(c, 0, 64'd1);
            push(c, 1, 64'(c));
            push(c, 2, 64'(2 * c));
            push(c, 3, 64'(2 * c + 1));
            push(c, 4, 64'(c));
        end
        for (int c = 0; c < NW / E; c++)
            for (int i = 0; i < E; i++)
                push(c, 32'h8000 + i, ucode_mem[c * E + i]);
        for (int c = 0; c < N; c++) push(c, 5, MODE_D);
        for (int c = 0; c < N; c++) push(c, 0, 64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) uidx = 0;
        else if (yumi_seen) uidx++;
        gap++;
        case (mode)
            0: begin bus.cfg_ready_i = 1'b1; bus.ucode_v_i = 1'b1; end
            1: begin
                bus.cfg_ready_i = ($urandom_range(0, 2) != 0);
                bus.ucode_v_i   = ($urandom_range(0, 1) != 0);
            end
            default: begin
                bus.cfg_ready_i = ($urandom_range(0, 2) != 0);
                bus.ucode_v_i   = (gap % 3 == 0);
            end
        endcase
    end

    always @(negedge clk) begin
        yumi_seen = rst_n && bus.ucode_yumi_o;
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            if (bus.ucode_yumi_o) yumi_ever = 1;
            if (hold_pend) begin
                chk("hold_valid", 128'(bus.cfg_v_o), 128'd1);
                chk("hold_payload", 128'({bus.cfg_core_o, bus.cfg_addr_o, bus.cfg_data_o}), 128'(hold_wr));
            end
            hold_pend = 0;
            if (bus.cfg_v_o && bus.cfg_ready_i) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL sb_underflow: got write addr %0h with nothing expected", bus.cfg_addr_o);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_core", 128'(bus.cfg_core_o), 128'(w.core));
                    chk("wr_addr", 128'(bus.cfg_addr_o), 128'(w.addr));
                    chk("wr_data", 128'(bus.cfg_data_o), 128'(w.data));
                end
            end else if (bus.cfg_v_o && bus.cfg_addr_o < 16'h8000) begin
                hold_pend = 1;
                hold_wr   = {bus.cfg_core_o, bus.cfg_addr_o, bus.cfg_data_o};
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_v"},    128'(bus.cfg_v_o), 128'd0);
        chk({tag, "_yumi"}, 128'(bus.ucode_yumi_o), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
        chk({tag, "_payload"}, 128'({bus.cfg_core_o, bus.cfg_addr_o, bus.cfg_data_o}), 128'd0);
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc == 1 && mode == 0) chk("first_valid_cycle1", 128'(bus.cfg_v_o), 128'd1);
        end
        if (!done) chk("done_timeout", 128'(done), 128'd1);
    endtask

    task automatic end_of_run(input string tag);
        chk({tag, "_sb_empty"}, 128'(exp_q.size()), 128'd0);
        chk({tag, "_writes"}, 128'(wr_cnt), 128'(T));
    endtask

    task automatic restart(input int m);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        build_exp();
        wr_cnt = 0;
        mode   = m;
        rst_n  = 1'b1;
    endtask

    initial begin
        int cyc;
        int u0;
        bus.cfg_ready_i = 1'b1;
        bus.ucode_v_i   = 1'b1;
        for (int i = 0; i < N * E; i++) ucode_mem[i] = {$urandom, $urandom};

        // No backpressure: exact latency of first write and of done.
        restart(0);
        #1 chk("cycle0_idle", 128'(bus.cfg_v_o), 128'd0);
        wait_done(200, cyc);
        chk("done_cycle", 128'(cyc), 128'(T + 1));
        end_of_run("runA");

        u0 = uidx;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_done_v", 128'(bus.cfg_v_o), 128'd0);
            chk("post_done_done", 128'(done), 128'd1);
        end
        chk("post_done_no_consume", 128'(uidx), 128'(u0));

        // Random ready and random microcode valid.
        restart(1);
        wait_done(3000, cyc);
        end_of_run("runB");

        // Gapped microcode, reset pulse partway through, then a full rerun.
        restart(2);
        cyc = 0;
        while (wr_cnt < 5 * N + 1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_mid_seq", 128'(wr_cnt >= 5 * N + 1), 128'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("async_reset");
        restart(2);
        wait_done(3000, cyc);
        end_of_run("runC");

`ifdef BP_CFG_LOADER_UCODE_EN
        chk("yumi_seen", 128'(yumi_ever), 128'd1);
`else
        chk("yumi_never", 128'(yumi_ever), 128'd0);
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/bp_cfg_loader.md
# bp_cfg_loader

Boot-time configuration sequencer directly downstream of the processor configuration selection: it consumes the elaborated core/LCE/CCE counts and CCE instruction-RAM depth of the selected processor config and drives every tile's config-register port over a single valid/ready write channel. It freezes all cores, assigns core/LCE/CCE IDs, streams CCE microcode, sets CCE mode and unfreezes, then raises `done_o`.

## Interface
- `num_core_p`, 1, cores to configure; equals the selected config's num_core.
- `num_cce_p`, 1, CCEs; must equal `num_core_p` (elaboration assertion).
- `num_lce_p`, 2, LCEs; must equal 2*`num_core_p` (elaboration assertion).
- `num_cce_instr_ram_els_p`, 256, microcode words per CCE.
- `cfg_addr_width_p`, 16, config register address width.
- `cfg_data_width_p`, 64, config write data width.
- `clk_i` in 1: sole clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `cfg_v_o` out 1: config write valid.
- `cfg_ready_i` in 1: target accepts write.
- `cfg_core_o` out clog2(`num_core_p`) (min 1): destination core.
- `cfg_addr_o` out `cfg_addr_width_p`: register address.
- `cfg_data_o` out `cfg_data_width_p`: write data, zero-extended.
- `ucode_v_i` in 1: microcode word available.
- `ucode_data_i` in `cfg_data_width_p`: microcode word.
- `ucode_yumi_o` out 1: microcode word consumed.
- `done_o` out 1: sequence complete; sticky until reset.

## Operation
- Address map: 0x0000 freeze, 0x0001 core_id, 0x0002 icache LCE id, 0x0003 dcache LCE id, 0x0004 CCE id, 0x0005 CCE mode, 0x8000+i CCE instr RAM word i.
- States: RESET -> IDS -> UCODE -> MODE -> UNFREEZE -> DONE.
- RESET: one idle cycle after reset release, then IDS.
- IDS: for core c = 0..N-1, writes in order: freeze=1, core_id=c, icache LCE=2c, dcache LCE=2c+1, CCE id=c.
- UCODE: for CCE c = 0..N-1, i = 0..E-1: addr 0x8000+i, data `ucode_data_i`, `cfg_core_o`=c. `cfg_v_o` = `ucode_v_i`; `ucode_yumi_o` = `ucode_v_i` & `cfg_ready_i`. Words consumed strictly in order; stream holds N*E words.
- MODE: per core, CCE mode=1 (normal).
- UNFREEZE: per core, freeze=0.
- DONE: `cfg_v_o`=0, `done_o`=1, `ucode_yumi_o`=0; further `ucode_v_i` ignored.
- Counters: core index wraps N-1 -> 0 on phase change; word index E-1 -> 0 advances CCE; sub-step counter 0..4 in IDS.

## Timing
- All outputs reset to 0 asynchronously on `reset_n_i`=0.
- Transfer when `cfg_v_o` & `cfg_ready_i` at rising edge; counters advance that edge, next write presented the following cycle. No combinational path `cfg_ready_i` -> `cfg_v_o`.
- Outside UCODE, `cfg_v_o`, address, data and core held stable while `cfg_ready_i`=0.
- In UCODE, payload is combinational from `ucode_data_i`; upstream holds it stable while `ucode_v_i`=1 and no yumi.
- First `cfg_v_o` in cycle 1 after reset release. With no backpressure: 7N + N*E writes, one per cycle; `done_o` rises the cycle after the last accepted write.
- Reset asserted mid-sequence: outputs zero immediately; after release restart from RESET, core 0, sub-step 0. Partially loaded microcode is re-sent in full.

## Configuration
- `BP_CFG_LOADER_UCODE_EN` defined: UCODE phase present, MODE writes data 1.
- Undefined: UCODE state removed, `ucode_yumi_o` tied 0, IDS -> MODE directly, MODE writes data 0 (uncached mode); total writes 7N.

## Test plan
- N=1, E=4, ready always 1, ucode 0xA0..0xA3: writes (0,0x0,1),(0,0x1,0),(0,0x2,0),(0,0x3,1),(0,0x4,0),0x8000..0x8003 with 0xA0..0xA3, (0,0x5,1),(0,0x0,0); `done_o` cycle 12.
- N=2, E=2, ready toggling 1/0: payload stable during ready=0; core 1 IDs 1,2,3,1; 18 transfers total, order unchanged.
- UCODE with `ucode_v_i` gapped (valid every third cycle): `cfg_v_o` mirrors `ucode_v_i`, yumi only with ready; no word dropped or duplicated.
- Reset pulse during UCODE word 1 of CCE 0: outputs 0 within the reset cycle; after release sequence restarts with (0,0x0,1).
- Macro undefined, N=2: 14 writes, MODE data 0, `ucode_yumi_o` never asserted.
- After `done_o`, `ucode_v_i`=1 and ready=1 for 10 cycles: `cfg_v_o`=0, `done_o` stays 1.
